lcd_frame_feeder: RTL
=====================

Name: lcd_frame_feeder

Overview:
Upstream word source for the LCD write-strobe controller. On start, streams an 11-word window/memory-write command preamble, then every pixel of the H_RES x V_RES frame read from a synchronous frame-buffer ROM. It drives the 16-bit LCD data bus and LCD_RS. It paces itself on the controller's addr_en pulse and holds the controller's en/data_stop inputs.

Parameters:
H_RES, 240, pixels per line (1..4095)
V_RES, 320, lines per frame (1..4095)
ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
start  input  1  single-cycle request to send one frame
addr_en  input  1  one-cycle pulse from write controller: current word consumed
wr_en  output  1  to controller en; high for the whole burst
wr_last  output  1  to controller data_stop; high while the final word is on the bus
lcd_data  output  16  LCD data bus
lcd_rs  output  1  0 = command word, 1 = data word
rd_addr  output  ADDR_W  frame-buffer read address (registered)
rd_data  input  16  frame-buffer data, valid 1 cycle after rd_addr, held while rd_addr is stable
busy  output  1  high from start acceptance until burst end
done  output  1  one-cycle pulse after the last word is consumed

Behaviour:
- Interface: reset rstn, asynchronous, active-low; clock clk. All outputs registered.
- Reset values: wr_en=0, wr_last=0, lcd_data=0, lcd_rs=1, rd_addr=0, busy=0, done=0, state=IDLE, word index=0.
- Word sequence, index 0..10+N with N=H_RES*V_RES; the RS value follows each word:
  - 0x002A RS0
  - 0x0000 RS1, 0x0000 RS1
  - {8'h0,(H_RES-1)[15:8]} RS1, {8'h0,(H_RES-1)[7:0]} RS1
  - 0x002B RS0
  - 0x0000 RS1, 0x0000 RS1
  - {8'h0,(V_RES-1)[15:8]} RS1, {8'h0,(V_RES-1)[7:0]} RS1
  - 0x002C RS0
  - N pixel words, RS1, in raster order from rd_addr 0..N-1.
- FSM states: IDLE, CMD, PIX.
  - IDLE: on start, next cycle enters CMD. Word 0 is placed on lcd_data/lcd_rs. busy=1, wr_en=1, rd_addr=0.
  - CMD: each addr_en loads the next word on the following edge. On addr_en while holding word 10, lcd_data<=rd_data, rd_addr<=1, and the state moves to PIX.
  - PIX: each addr_en causes lcd_data<=rd_data and rd_addr<=rd_addr+1. rd_addr always points to the pixel after the one on the bus.
- wr_last is registered. It is 1 exactly while word 10+N is presented, so it is valid combinationally during the controller's ADDR cycle.
- End of burst: addr_en with wr_last=1 causes these updates on the next edge:
  - wr_en=0, wr_last=0, busy=0, done=1 for one cycle
  - state returns to IDLE
  - rd_addr=0, lcd_rs=1
  - lcd_data holds its last value
- Data stability: lcd_data and lcd_rs change only on the edge after addr_en, i.e. the controller's WAIT cycle. They are stable through WR_L/WR_H.
- start while busy is ignored. start coincident with done is accepted, and the next burst begins the cycle after.
- addr_en in IDLE is ignored.
- rd_addr never exceeds N-1. It is not incremented past the last pixel. Wrap to 0 occurs only at end of burst.
- Reset mid-burst: all outputs return to reset values immediately and no done pulse is issued.
- Minimum H_RES=V_RES=1: preamble then a single pixel. wr_last is asserted with that pixel.

Optional Feature:
LCD_FEED_PATTERN_EN
- With the macro: adds input pattern_sel (1 bit, sampled at start) and an internal column counter.
  - When the sampled pattern_sel=1, each pixel word is an 8-bar RGB565 colour-bar value chosen by column*8/H_RES. The bar sequence is white, yellow, cyan, green, magenta, red, blue, black = 0xFFFF, 0xFFE0, 0x07FF, 0x07E0, 0xF81F, 0xF800, 0x001F, 0x0000.
  - rd_addr still advances identically, but rd_data is ignored.
- Without the macro: no pattern_sel port, no column counter, and pixels always come from rd_data.

Test Plan:
- H_RES=4, V_RES=2, model controller (addr_en every 4 cycles), ROM data=addr+0x100, start pulse -> 19 words: 0x2A, 0, 0, 0, 3, 0x2B, 0, 0, 0, 1, 0x2C, then 0x100..0x107. RS pattern is 0,1,1,1,1,0,1,1,1,1,0,1x8. wr_last is high only with 0x107. done pulses once and wr_en falls the edge after the final addr_en.
- Same setup: check lcd_data/lcd_rs never change in the 2 cycles after an addr_en+1 edge -> stable through the WR_L/WR_H window.
- start asserted at word 5 of a burst -> ignored. Exactly 19 words are sent and there is one done pulse.
- rstn low at pixel 3 -> wr_en=0, busy=0, rd_addr=0, lcd_rs=1 immediately, and no done. A subsequent start gives a full fresh burst from 0x002A.
- H_RES=V_RES=1 -> 12 words, the last being ROM[0] with wr_last=1. rd_addr stays 0 throughout the pixel phase.
- With LCD_FEED_PATTERN_EN, H_RES=8, V_RES=1, pattern_sel=1 -> pixels 0xFFFF, 0xFFE0, 0x07FF, 0x07E0, 0xF81F, 0xF800, 0x001F, 0x0000, regardless of rd_data.

Source files
------------

// File: rtl/lcd_frame_feeder.sv
// lcd_frame_feeder: streams an 11-word window/memory-write preamble, then H_RES*V_RES frame-buffer pixels, to the LCD write-strobe controller.
// Latency: word 0 is on the bus the cycle after start; each addr_en loads the next word on the following edge (ROM read is hidden behind the controller's strobe cycles).
// Backpressure: fully paced by addr_en; lcd_data/lcd_rs hold until the next addr_en. Optional macro LCD_FEED_PATTERN_EN adds pattern_sel for 8-bar colour-bar pixels.
module lcd_frame_feeder #(
   parameter int H_RES  = 240,
   parameter int V_RES  = 320,
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              addr_en,
`ifdef LCD_FEED_PATTERN_EN
   input  logic              pattern_sel,
`endif
   output logic              wr_en,
   output logic              wr_last,
   output logic [15:0]       lcd_data,
   output logic              lcd_rs,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [15:0]       rd_data,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, CMD, PIX} state_t;

   localparam int                N         = H_RES * V_RES;
   localparam logic [15:0]       HM1       = 16'(H_RES - 1);
   localparam logic [15:0]       VM1       = 16'(V_RES - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
   localparam logic              ONE_PIX   = (N == 1);

   state_t              state, state_nx;
   logic [3:0]          idx, idx_nx;
   logic                wr_en_nx, wr_last_nx, lcd_rs_nx, busy_nx, done_nx;
   logic [15:0]         lcd_data_nx;
   logic [ADDR_W-1:0]   rd_addr_nx;
   logic [15:0]         pix_word;

   // Preamble word table, returned as {rs, data}.
   function automatic logic [16:0] preamble(input logic [3:0] i);
      case (i)
         4'd0:    preamble = {1'b0, 16'h002A};
         4'd3:    preamble = {1'b1, 8'h00, HM1[15:8]};
         4'd4:    preamble = {1'b1, 8'h00, HM1[7:0]};
         4'd5:    preamble = {1'b0, 16'h002B};
         4'd8:    preamble = {1'b1, 8'h00, VM1[15:8]};
         4'd9:    preamble = {1'b1, 8'h00, VM1[7:0]};
         4'd10:   preamble = {1'b0, 16'h002C};
         default: preamble = {1'b1, 16'h0000};
      endcase
   endfunction

`ifdef LCD_FEED_PATTERN_EN
   localparam logic [14:0] HRES15 = 15'(H_RES);
   logic        pat_q, pat_nx;
   logic [11:0] col, col_nx, col_inc;
   logic [14:0] bar;

   // Colour bar for the column being loaded; rd_data ignored when pattern selected.
   always_comb begin
      bar     = {col, 3'b000} / HRES15;
      col_inc = (col == 12'(H_RES - 1)) ? 12'd0 : col + 12'd1;
      case (bar)
         15'd0:   pix_word = 16'hFFFF;
         15'd1:   pix_word = 16'hFFE0;
         15'd2:   pix_word = 16'h07FF;
         15'd3:   pix_word = 16'h07E0;
         15'd4:   pix_word = 16'hF81F;
         15'd5:   pix_word = 16'hF800;
         15'd6:   pix_word = 16'h001F;
         default: pix_word = 16'h0000;
      endcase
      if (!pat_q)
         pix_word = rd_data;
   end
`else
   assign pix_word = rd_data;
`endif

   // Next-state and next-output logic; all outputs are registered from these.
   always_comb begin
      state_nx    = state;
      idx_nx      = idx;
      wr_en_nx    = wr_en;
      wr_last_nx  = wr_last;
      lcd_data_nx = lcd_data;
      lcd_rs_nx   = lcd_rs;
      rd_addr_nx  = rd_addr;
      busy_nx     = busy;
      done_nx     = 1'b0;
`ifdef LCD_FEED_PATTERN_EN
      pat_nx      = pat_q;
      col_nx      = col;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               state_nx    = CMD;
               idx_nx      = 4'd0;
               lcd_data_nx = 16'h002A;
               lcd_rs_nx   = 1'b0;
               wr_en_nx    = 1'b1;
               wr_last_nx  = 1'b0;
               busy_nx     = 1'b1;
               rd_addr_nx  = '0;
`ifdef LCD_FEED_PATTERN_EN
               pat_nx      = pattern_sel;
               col_nx      = 12'd0;
`endif
            end
         end
         CMD: begin
            if (addr_en) begin
               if (idx == 4'd10) begin
                  // rd_addr has sat at 0 since start, so rd_data already holds pixel 0.
                  state_nx    = PIX;
                  lcd_data_nx = pix_word;
                  lcd_rs_nx   = 1'b1;
                  rd_addr_nx  = ONE_PIX ? '0 : ADDR_W'(1);
                  wr_last_nx  = ONE_PIX;
`ifdef LCD_FEED_PATTERN_EN
                  col_nx      = col_inc;
`endif
               end else begin
                  idx_nx                   = idx + 4'd1;
                  {lcd_rs_nx, lcd_data_nx} = preamble(idx + 4'd1);
               end
            end
         end
         PIX: begin
            if (addr_en) begin
               if (wr_last) begin
                  state_nx   = IDLE;
                  idx_nx     = 4'd0;
                  wr_en_nx   = 1'b0;
                  wr_last_nx = 1'b0;
                  busy_nx    = 1'b0;
                  done_nx    = 1'b1;
                  rd_addr_nx = '0;
                  lcd_rs_nx  = 1'b1;
               end else begin
                  lcd_data_nx = pix_word;
`ifdef LCD_FEED_PATTERN_EN
                  col_nx      = col_inc;
`endif
                  // rd_addr points one ahead; at the final pixel it stays put.
                  if (rd_addr == LAST_ADDR)
                     wr_last_nx = 1'b1;
                  else
                     rd_addr_nx = rd_addr + ADDR_W'(1);
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         idx      <= 4'd0;
         wr_en    <= 1'b0;
         wr_last  <= 1'b0;
         lcd_data <= 16'h0000;
         lcd_rs   <= 1'b1;
         rd_addr  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef LCD_FEED_PATTERN_EN
         pat_q    <= 1'b0;
         col      <= 12'd0;
`endif
      end else begin
         state    <= state_nx;
         idx      <= idx_nx;
         wr_en    <= wr_en_nx;
         wr_last  <= wr_last_nx;
         lcd_data <= lcd_data_nx;
         lcd_rs   <= lcd_rs_nx;
         rd_addr  <= rd_addr_nx;
         busy     <= busy_nx;
         done     <= done_nx;
`ifdef LCD_FEED_PATTERN_EN
         pat_q    <= pat_nx;
         col      <= col_nx;
`endif
      end
   end

endmodule
